ultrasonic_echo_responder: RTL and testbench
============================================

# ultrasonic_echo_responder

Behavioural HC-SR04 responder: the sensor end of the trig/echo protocol that the fan's ultrasonic distance controller drives. It watches `trig`, validates the pulse width, waits a fixed burst delay, then drives `echo` high for a time proportional to a programmed distance in 0.1 cm units. It is used as a synthesizable stand-in for the sensor on the board, for hardware-in-the-loop tests of the auto-pause feature, and as the bench model in simulation. The clock is 100 MHz.

## Interface
- `CYC_PER_UNIT`, default 580: clk cycles of echo per 0.1 cm (58 µs/cm).
- `MIN_TRIG`, default 1000: minimum valid trig high time in cycles (10 µs).
- `BURST_DELAY`, default 25_000: cycles from the accepted trig fall to the echo rise (250 µs).
- `MAX_DIST`, default 4000: largest in-range distance in 0.1 cm units (400 cm).
- `TIMEOUT_CYC`, default 3_800_000: echo width in cycles for a no-target or out-of-range response (38 ms).
- `HOLDOFF`, default 100_000: dead time in cycles after the echo fall before a new trig is accepted.
- `clk` (in, 1): system clock.
- `reset_p` (in, 1): asynchronous, active-high reset.
- `trig` (in, 1): trigger from the controller. May be asynchronous; it passes through a 2-flop synchronizer.
- `distance` (in, 12): target distance in 0.1 cm units. Sampled once per measurement.
- `echo` (out, 1): echo pulse to the controller. Registered.
- `busy` (out, 1): high from trig acceptance until holdoff expires.
- `done` (out, 1): 1-cycle pulse on the cycle echo falls.
- `short_trig` (out, 1): 1-cycle pulse when a trig pulse shorter than `MIN_TRIG` is rejected.

## Operation
- `trig_s` is the 2-flop synchronized `trig`. `trig_d` is `trig_s` delayed by one cycle.
- Rise = `trig_s & ~trig_d`. Fall = `~trig_s & trig_d`.
- FSM states, one-hot: IDLE, TRIG_HIGH, DELAY, ECHO, HOLDOFF.
- IDLE: on a rise, clear the width counter and go to TRIG_HIGH. A trig that is already high when IDLE is entered is ignored until it falls and rises again.
- TRIG_HIGH: count cycles while `trig_s` is high. The counter saturates at `MIN_TRIG`.
  - On a fall with count ≥ `MIN_TRIG`: latch `distance` into `dist_l` and go to DELAY.
  - On a fall with count < `MIN_TRIG`: pulse `short_trig` and return to IDLE.
- DELAY: count `BURST_DELAY` cycles, then set `echo` and go to ECHO.
- ECHO: hold `echo` high for exactly W cycles, then clear `echo`, pulse `done`, and go to HOLDOFF.
  - W = `dist_l * CYC_PER_UNIT` when 1 ≤ `dist_l` ≤ `MAX_DIST`.
  - W = `TIMEOUT_CYC` when `dist_l` == 0 or `dist_l` > `MAX_DIST`.
- HOLDOFF: count `HOLDOFF` cycles, then go to IDLE.
- Arithmetic: the echo width counter is 22 bits; the maximum is 3_800_000 < 2^22. A multiplier-free implementation is allowed (a sub-counter 0..`CYC_PER_UNIT`-1 plus a unit counter), provided W is exact.
- `busy` = state ≠ IDLE.
- `distance` changes after the latch do not affect the current echo.
- Trig activity in DELAY, ECHO or HOLDOFF is ignored. It produces no `short_trig`.
- An undefined state returns to IDLE with all outputs low.

## Timing
- Reset values: `echo` = 0, `busy` = 0, `done` = 0, `short_trig` = 0; state = IDLE; all counters = 0.
- Reset is asynchronous, so assertion mid-echo drops `echo` immediately.
- Trig input latency: a change on `trig` is visible in `trig_s` 2 cycles later. Rise and fall are detected one cycle after that.
- Let F be the clk edge at which the valid fall is detected (the state leaves TRIG_HIGH). Then:
  - `busy` is high from the edge after the rise detection through F+`BURST_DELAY`+W+`HOLDOFF`-1.
  - `echo` rises at edge F+`BURST_DELAY`.
  - `echo` falls at edge F+`BURST_DELAY`+W.
  - `done` is high for the cycle following F+`BURST_DELAY`+W.
  - The state is IDLE (`busy` low) at F+`BURST_DELAY`+W+`HOLDOFF`.
- `short_trig` is asserted for the one cycle following the short fall detection.

## Test plan
- Nominal measurement: `distance`=500, trig high 1000 cycles -> `echo` rises 25_000 cycles after F, stays high exactly 290_000 cycles, one `done` pulse.
- Range limits:
  - `distance`=1 -> W=580.
  - `distance`=4000 -> W=2_320_000.
  - `distance`=4001 or 0 -> W=3_800_000.
- Trig width boundary:
  - Trig high 999 cycles -> `short_trig` pulse, `echo` stays 0, `busy` returns to 0.
  - Trig high exactly 1000 cycles -> accepted.
  - Trig high 50_000 cycles -> accepted, `echo` timed from the fall.
- Busy rejection: a second 1000-cycle trig issued during ECHO and another during HOLDOFF -> ignored, no `short_trig`. A trig issued after `busy` falls -> accepted.
- Distance latch: change `distance` 500 -> 100 during DELAY -> W=290_000. A trig held high across the holdoff end -> no measurement until a fresh rise.
- Reset mid-echo: assert `reset_p` 1000 cycles into ECHO -> `echo`, `busy` and `done` go 0 immediately. After release, a valid trig gives a normal response.

Source files
------------

// File: rtl/ultrasonic_echo_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ultrasonic_echo_responder
// Brief    : HC-SR04 sensor-side responder. Validates the trig pulse width,
//            waits a fixed burst delay, then drives echo high for a width
//            proportional to the programmed distance (0.1 cm units).
// Revision : 1.0 - initial release
// ============================================================================
module ultrasonic_echo_responder #(
  parameter int CYC_PER_UNIT = 580,
  parameter int MIN_TRIG     = 1000,
  parameter int BURST_DELAY  = 25_000,
  parameter int MAX_DIST     = 4000,
  parameter int TIMEOUT_CYC  = 3_800_000,
  parameter int HOLDOFF      = 100_000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        trig,
  input  logic [11:0] distance,
  output logic        echo,
  output logic        busy,
  output logic        done,
  output logic        short_trig
);

  localparam logic [21:0] c_CYC_PER_UNIT = 22'(CYC_PER_UNIT);
  localparam logic [21:0] c_MIN_TRIG     = 22'(MIN_TRIG);
  localparam logic [21:0] c_MIN_TRIG_M1  = 22'(MIN_TRIG - 1);
  localparam logic [21:0] c_BURST_M1     = 22'(BURST_DELAY - 1);
  localparam logic [21:0] c_HOLDOFF_M1   = 22'(HOLDOFF - 1);
  localparam logic [21:0] c_TIMEOUT      = 22'(TIMEOUT_CYC);
  localparam logic [11:0] c_MAX_DIST     = 12'(MAX_DIST);

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_TRIG_HIGH = 5'b00010,
    S_DELAY     = 5'b00100,
    S_ECHO      = 5'b01000,
    S_HOLDOFF   = 5'b10000
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_trig_m;
  logic        r_trig_s;
  logic        r_trig_d;
  logic        w_rise;
  logic        w_fall;

  logic [21:0] r_cnt;
  logic [21:0] w_cnt_nxt;
  logic [21:0] w_cnt_inc;
  logic [11:0] r_dist_l;
  logic [11:0] w_dist_nxt;
  logic [21:0] w_echo_w;
  logic [21:0] w_echo_w_m1;

  logic        r_echo;
  logic        w_echo_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_short;
  logic        w_short_nxt;

  assign w_rise    = r_trig_s & ~r_trig_d;
  assign w_fall    = ~r_trig_s & r_trig_d;
  assign w_cnt_inc = r_cnt + 22'd1;

  // Zero and anything beyond the sensor range answer with the no-target width.
  assign w_echo_w    = ((r_dist_l != 12'd0) && (r_dist_l <= c_MAX_DIST))
                     ? ({10'd0, r_dist_l} * c_CYC_PER_UNIT) : c_TIMEOUT;
  assign w_echo_w_m1 = w_echo_w - 22'd1;

  assign echo       = r_echo;
  assign done       = r_done;
  assign short_trig = r_short;
  assign busy       = (r_state == S_TRIG_HIGH) || (r_state == S_DELAY) ||
                      (r_state == S_ECHO) || (r_state == S_HOLDOFF);

  // Two-flop synchronizer for the asynchronous trig plus one edge-detect stage.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_trig_m <= 1'b0;
      r_trig_s <= 1'b0;
      r_trig_d <= 1'b0;
    end else begin
      r_trig_m <= trig;
      r_trig_s <= r_trig_m;
      r_trig_d <= r_trig_s;
    end
  end

  // State, shared phase counter, latched distance and registered outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dist_l <= '0;
      r_echo   <= 1'b0;
      r_done   <= 1'b0;
      r_short  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dist_l <= w_dist_nxt;
      r_echo   <= w_echo_nxt;
      r_done   <= w_done_nxt;
      r_short  <= w_short_nxt;
    end
  end

  // Next-state and next-output decode; every phase ends when r_cnt hits length-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dist_nxt  = r_dist_l;
    w_echo_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_short_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = S_TRIG_HIGH;
        end
      end
      S_TRIG_HIGH: begin
        if (w_fall) begin
          w_cnt_nxt = '0;
          // The rise-detect cycle was already a high cycle, so width = r_cnt + 1.
          if (r_cnt >= c_MIN_TRIG_M1) begin
            w_dist_nxt  = distance;
            w_state_nxt = S_DELAY;
          end else begin
            w_short_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (r_trig_s && (r_cnt < c_MIN_TRIG)) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_DELAY: begin
        if (r_cnt == c_BURST_M1) begin
          w_cnt_nxt   = '0;
          w_echo_nxt  = 1'b1;
          w_state_nxt = S_ECHO;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_ECHO: begin
        if (r_cnt == w_echo_w_m1) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_HOLDOFF;
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_echo_nxt = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (r_cnt == c_HOLDOFF_M1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_echo_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ultrasonic_echo_responder
// Brief    : Scoreboard bench for ultrasonic_echo_responder with shortened
//            timing parameters; stimulus pushes expected responses, a monitor
//            pops and compares them as echo / short_trig appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_echo_responder;

  localparam int P_CPU   = 5;
  localparam int P_MIN   = 10;
  localparam int P_BD    = 50;
  localparam int P_MAX   = 40;
  localparam int P_TO    = 300;
  localparam int P_HO    = 100;
  localparam int P_ABORT = 100;

  localparam int K_ECHO  = 0;
  localparam int K_SHORT = 1;
  localparam int K_ABORT = 2;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        trig;
  logic [11:0] distance;
  logic        echo;
  logic        busy;
  logic        done;
  logic        short_trig;

  typedef struct {
    int     kind;
    longint rise;
    longint width;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;

  ultrasonic_echo_responder #(
    .CYC_PER_UNIT (P_CPU),
    .MIN_TRIG     (P_MIN),
    .BURST_DELAY  (P_BD),
    .MAX_DIST     (P_MAX),
    .TIMEOUT_CYC  (P_TO),
    .HOLDOFF      (P_HO)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .trig       (trig),
    .distance   (distance),
    .echo       (echo),
    .busy       (busy),
    .done       (done),
    .short_trig (short_trig)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: echo width from the distance rules.
  function automatic longint ref_width(input int d);
    if (d >= 1 && d <= P_MAX) return longint'(d) * P_CPU;
    return P_TO;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Drive one trig pulse of n cycles and record the expected response.
  task automatic launch(input int n, input int d, input bit abort, output longint idle_c);
    exp_t   e;
    longint fall_c;
    distance = 12'(d);
    trig = 1'b1;
    repeat (n) @(negedge clk);
    trig = 1'b0;
    fall_c = cyc;
    if (n >= P_MIN) begin
      e.kind  = abort ? K_ABORT : K_ECHO;
      e.rise  = fall_c + 3 + P_BD;
      e.width = abort ? (P_ABORT + 1) : ref_width(d);
      idle_c  = fall_c + 3 + P_BD + ref_width(d) + P_HO;
    end else begin
      e.kind  = K_SHORT;
      e.rise  = fall_c + 3;
      e.width = 0;
      idle_c  = fall_c + 3;
    end
    sb.push_back(e);
  endtask

  task automatic pulse(input int n);
    trig = 1'b1;
    repeat (n) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_idle(input longint idle_c);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 5000) begin
      if (k == 4) distance = 12'($urandom);
      @(negedge clk);
      k++;
    end
    if (busy) fail_now("busy_timeout");
    else chk("idle_cycle", cyc, idle_c);
  endtask

  task automatic wait_echo(input logic lvl);
    int k;
    k = 0;
    while (echo !== lvl && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (echo !== lvl) fail_now("echo_wait_timeout");
  endtask

  task automatic run(input int n, input int d);
    longint idle_c;
    launch(n, d, 1'b0, idle_c);
    wait_idle(idle_c);
    repeat (5) @(negedge clk);
  endtask

  // Monitor: pops an expectation whenever short_trig pulses or an echo ends.
  initial begin : monitor
    exp_t   e;
    logic   echo_prev;
    longint start_c;
    longint hi;
    echo_prev = 1'b0;
    start_c = 0;
    hi = 0;
    forever begin
      @(negedge clk);
      if (short_trig === 1'b1) begin
        if (sb.size() == 0) fail_now("unexpected_short_trig");
        else begin
          e = sb.pop_front();
          if (e.kind != K_SHORT) fail_now("short_trig_instead_of_echo");
          else chk("short_trig_cycle", cyc, e.rise);
        end
      end
      if (echo === 1'b1 && !echo_prev) begin
        start_c = cyc;
        hi = 0;
      end
      if (echo === 1'b1) hi++;
      if (echo !== 1'b1 && echo_prev) begin
        if (sb.size() == 0) fail_now("unexpected_echo");
        else begin
          e = sb.pop_front();
          if (e.kind == K_SHORT) fail_now("echo_instead_of_short_trig");
          else begin
            chk("echo_rise_cycle", start_c, e.rise);
            chk("echo_width", hi, e.width);
            chk("done_at_fall", done, (e.kind == K_ECHO) ? 1 : 0);
          end
        end
      end
      echo_prev = (echo === 1'b1);
    end
  end

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    longint idle_c;
    reset_p  = 1'b1;
    trig     = 1'b0;
    distance = 12'd0;
    repeat (3) @(negedge clk);
    chk("reset_echo", echo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_short", short_trig, 0);
    reset_p = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal and range limits
    run(P_MIN, 25);
    run(P_MIN, 1);
    run(P_MIN, P_MAX);
    run(P_MIN, P_MAX + 1);
    run(P_MIN, 0);
    run(P_MIN, 4095);

    // Trig width boundary
    run(P_MIN - 1, 20);
    run(P_MIN, 20);
    run(500, 20);

    // Trigs during ECHO and HOLDOFF are ignored
    launch(P_MIN, 10, 1'b0, idle_c);
    wait_echo(1'b1);
    pulse(P_MIN);
    wait_echo(1'b0);
    repeat (10) @(negedge clk);
    pulse(P_MIN);
    wait_idle(idle_c);
    repeat (5) @(negedge clk);
    run(P_MIN, 15);

    // Distance change after the latch has no effect
    launch(P_MIN, 30, 1'b0, idle_c);
    repeat (20) @(negedge clk);
    distance = 12'd5;
    wait_idle(idle_c);
    repeat (5) @(negedge clk);

    // Trig held across the holdoff end does not re-arm
    launch(P_MIN, 8, 1'b0, idle_c);
    wait_echo(1'b1);
    wait_echo(1'b0);
    repeat (20) @(negedge clk);
    trig = 1'b1;
    wait_idle(idle_c);
    repeat (20) @(negedge clk);
    trig = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_rearm_busy", busy, 0);
    run(P_MIN, 8);

    // Asynchronous reset in the middle of an echo
    launch(P_MIN, 30, 1'b1, idle_c);
    wait_echo(1'b1);
    repeat (P_ABORT) @(negedge clk);
    #2 reset_p = 1'b1;
    #1;
    chk("async_reset_echo", echo, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    reset_p = 1'b0;
    repeat (5) @(negedge clk);
    run(P_MIN, 30);

    // Randomized measurements
    for (int i = 0; i < 20; i++) begin
      int n;
      int d;
      case ($urandom_range(0, 3))
        0:       n = P_MIN - 1;
        1:       n = P_MIN;
        default: n = int'($urandom_range(1, 3 * P_MIN));
      endcase
      if ($urandom_range(0, 4) == 0) d = int'($urandom_range(0, 4095));
      else d = int'($urandom_range(0, P_MAX + 2));
      run(n, d);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
